// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: byte-strobed writable registers, read-only
// status registers fed from reg_in, SLVERR on out-of-range or read-only writes.
module axi4lite_regbank #(
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 8,
  parameter int                             ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_arr_t;

  reg_arr_t              regs_r;
  reg_arr_t              status_s;
  logic                  aw_held_r;
  logic                  w_held_r;
  logic [IDX_W-1:0]      aw_idx_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [STRB_W-1:0]     w_strb_r;
  logic                  awready_r;
  logic                  wready_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic [NUM_REGS-1:0]   wr_pulse_r;
  logic                  arready_r;
  logic                  rvalid_r;
  logic [1:0]            rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  ar_hs_s;
  logic                  commit_s;
  logic                  aw_held_nxt_s;
  logic                  w_held_nxt_s;
  logic                  bvalid_nxt_s;
  logic                  rvalid_nxt_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [STRB_W-1:0]     wr_strb_s;
  logic [NUM_REGS-1:0]   wr_sel_s;
  logic                  rd_hit_s;
  logic                  unused_s;

  assign status_s = reg_in;
  assign unused_s = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0], reg_in};

  // Write decode: a commit needs both address and data, held or arriving this edge
  always_comb begin
    aw_hs_s       = AWVALID && awready_r;
    w_hs_s        = WVALID && wready_r;
    commit_s      = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    wr_idx_s      = aw_held_r ? aw_idx_r : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    wr_data_s     = w_held_r ? w_data_r : WDATA;
    wr_strb_s     = w_held_r ? w_strb_r : WSTRB;
    aw_held_nxt_s = (aw_held_r || aw_hs_s) && !commit_s;
    w_held_nxt_s  = (w_held_r || w_hs_s) && !commit_s;
    bvalid_nxt_s  = commit_s || (bvalid_r && !BREADY);
    wr_sel_s      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel_s[i] = commit_s && !RO_MASK[i] && (wr_idx_s == IDX_W'(i));
    end
  end

  // Read decode: an index matching no register leaves rd_hit_s low (SLVERR, zero data)
  always_comb begin
    ar_hs_s      = ARVALID && arready_r;
    rd_idx_s     = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    rvalid_nxt_s = ar_hs_s || (rvalid_r && !RREADY);
    rd_data_s    = '0;
    rd_hit_s     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_hit_s  = rd_hit_s || (rd_idx_s == IDX_W'(i));
      rd_data_s = rd_data_s | ({DATA_WIDTH{rd_idx_s == IDX_W'(i)}} &
                               (RO_MASK[i] ? status_s[i] : regs_r[i]));
    end
  end

  // Write channel state, response and register storage
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_idx_r   <= '0;
      w_data_r   <= '0;
      w_strb_r   <= '0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= '0;
      regs_r     <= RESET_VAL;
    end else begin
      aw_held_r <= aw_held_nxt_s;
      w_held_r  <= w_held_nxt_s;
      if (aw_hs_s) begin
        aw_idx_r <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs_s) begin
        w_data_r <= WDATA;
        w_strb_r <= WSTRB;
      end
      awready_r  <= !aw_held_nxt_s && !bvalid_nxt_s;
      wready_r   <= !w_held_nxt_s && !bvalid_nxt_s;
      bvalid_r   <= bvalid_nxt_s;
      if (commit_s) begin
        bresp_r <= (|wr_sel_s) ? RESP_OKAY : RESP_SLVERR;
      end
      wr_pulse_r <= wr_sel_s;
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_sel_s[i] && wr_strb_s[b]) begin
            regs_r[i][8*b +: 8] <= wr_data_s[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: data sampled at the AR handshake edge, so a same-edge write is not visible
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
    end else begin
      arready_r <= !rvalid_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      if (ar_hs_s) begin
        rdata_r <= rd_data_s;
        rresp_r <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign AWREADY      = awready_r;
  assign WREADY       = wready_r;
  assign BVALID       = bvalid_r;
  assign BRESP        = bresp_r;
  assign ARREADY      = arready_r;
  assign RVALID       = rvalid_r;
  assign RDATA        = rdata_r;
  assign RRESP        = rresp_r;
  assign reg_out      = regs_r;
  assign reg_wr_pulse = wr_pulse_r;

endmodule
